norm_sequencer: RTL

- Streams rows of signed 32-bit accumulator results through one external `normalizer` instance (fixed 3-cycle latency, no stall input).
- Supplies per-column gain/bias/shift from an internal parameter table.
- Regains backpressure with a credit-guarded result FIFO, and re-attaches row framing (last flag) to normalized outputs.
- Sits between the systolic-array accumulator drain and the activation/writeback stage.

---
 rtl/norm_pkg.sv | 31 +++
 rtl/norm_result_fifo.sv | 61 ++++++
 rtl/norm_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/norm_pkg.sv
// Shared constants and types for the normalization sequencer.
package norm_pkg;

    // Fixed pipeline depth of the external normalizer.
    localparam int NORM_LATENCY = 3;

    // Identity transform: (x * 256) >>> 8 + 0 == x.
    localparam logic signed [15:0] GAIN_ONE  = 16'sd256;
    localparam logic [4:0]         SHIFT_ONE = 5'd8;

    typedef struct packed {
        logic signed [15:0] gain;
        logic signed [31:0] bias;
        logic [4:0]         shift;
    } norm_param_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } seq_state_e;

    function automatic norm_param_t identity_param();
        norm_param_t p;
        p.gain  = GAIN_ONE;
        p.bias  = '0;
        p.shift = SHIFT_ONE;
        return p;
    endfunction

endpackage

// File: rtl/norm_result_fifo.sv
// First-word-fall-through result FIFO with an occupancy count output.
module norm_result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    // A push into a full FIFO is still legal when the same cycle frees a slot.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    // Data storage; only pointers need reset, stale words are never exposed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/norm_sequencer.sv
// Streams accumulator rows through an external fixed-latency normalizer,
// supplying per-column parameters and re-attaching row framing on return.
//
// state  | meaning
// IDLE   | no row open; parameter table writable
// STREAM | row open, accepting elements
// DRAIN  | last element issued; waiting for it to leave the result FIFO
module norm_sequencer
    import norm_pkg::*;
#(
    parameter int NUM_COLS   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_we,
    input  logic [$clog2(NUM_COLS)-1:0] cfg_addr,
    input  logic signed [15:0]          cfg_gain,
    input  logic signed [31:0]          cfg_bias,
    input  logic [4:0]                  cfg_shift,
    output logic                        cfg_ready,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [31:0]          in_data,
    input  logic                        in_last,
    output logic                        norm_valid_in,
    output logic signed [31:0]          norm_data_in,
    output logic signed [15:0]          norm_gain,
    output logic signed [31:0]          norm_bias,
    output logic [4:0]                  norm_shift,
    input  logic                        norm_valid_out,
    input  logic signed [31:0]          norm_data_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [31:0]          out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic                        err_len
);

    localparam int CAW = $clog2(NUM_COLS);
    localparam int IFW = $clog2(NORM_LATENCY + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int CRW = $clog2(FIFO_DEPTH + NORM_LATENCY + 1);

    seq_state_e              state;
    seq_state_e              state_next;
    logic [CAW-1:0]          col;
    logic [IFW-1:0]          inflight;
    logic [NORM_LATENCY-1:0] last_pipe;
    norm_param_t             param_tab [NUM_COLS];
    norm_param_t             cur_param;
    logic [CRW-1:0]          credit_sum;
    logic                    credit_ok;
    logic                    issue;
    logic                    at_last_col;
    logic                    issue_last;
    logic                    overlength;
    logic                    ret;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic [FCW-1:0]          fifo_count;
    logic [32:0]             fifo_rd;

    // Every issued element is either inside the normalizer or in the FIFO,
    // so bounding their sum keeps the non-stallable return path from overflowing.
    assign credit_sum  = CRW'(inflight) + CRW'(fifo_count);
    assign credit_ok   = credit_sum < CRW'(FIFO_DEPTH);
    assign in_ready    = credit_ok & (state != DRAIN);
    assign issue       = in_valid & in_ready;
    assign at_last_col = (col == CAW'(NUM_COLS - 1));
    assign issue_last  = in_last | at_last_col;
    assign overlength  = issue & ~in_last & at_last_col;
    assign cur_param   = param_tab[col];

    assign norm_valid_in = issue;
    assign norm_data_in  = issue ? in_data        : '0;
    assign norm_gain     = issue ? cur_param.gain  : '0;
    assign norm_bias     = issue ? cur_param.bias  : '0;
    assign norm_shift    = issue ? cur_param.shift : '0;

    // Returns with nothing outstanding are stray; they are dropped, not queued.
    assign ret = norm_valid_out & (inflight != '0);

    norm_result_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ret),
        .push_data ({norm_data_out, last_pipe[NORM_LATENCY-1]}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = ~fifo_empty;
    assign fifo_pop  = out_valid & out_ready;
    assign out_data  = out_valid ? fifo_rd[32:1] : '0;
    assign out_last  = out_valid & fifo_rd[0];
    assign busy      = (state != IDLE) | out_valid;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and table-write gating.
    always_comb begin
        state_next = state;
        cfg_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (issue) begin
                    state_next = issue_last ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (issue && issue_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_pop && fifo_rd[0] && inflight == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Column position, overlength flag, outstanding count and last-flag delay line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col       <= '0;
            err_len   <= 1'b0;
            inflight  <= '0;
            last_pipe <= '0;
        end else begin
            if (issue) begin
                col <= issue_last ? '0 : col + 1'b1;
            end
            if (overlength) begin
                err_len <= 1'b1;
            end
            if (issue && !ret) begin
                inflight <= inflight + 1'b1;
            end else if (!issue && ret) begin
                inflight <= inflight - 1'b1;
            end
            last_pipe <= {last_pipe[NORM_LATENCY-2:0], issue & issue_last};
        end
    end

    // Per-column parameter table, writable only between rows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                param_tab[i] <= identity_param();
            end
        end else if (cfg_we && cfg_ready) begin
            param_tab[cfg_addr] <= '{gain: cfg_gain, bias: cfg_bias, shift: cfg_shift};
        end
    end

    // The normalizer must never return more results than were issued.
    assert property (@(posedge clk) disable iff (reset) norm_valid_out |-> (inflight != '0));

endmodule
